// File: rtl/display_scan_ctrl.sv
// HUB75-style panel scan controller: fetches pixels, shifts one bit-plane per row-pair, latches
// it and lights it for a binary-weighted time. Define DISPLAY_BRIGHTNESS_EN for a global dimmer.
module display_scan_ctrl #(
    parameter int unsigned NUM_COLS       = 64,
    parameter int unsigned NUM_ROWS       = 32,
    parameter int unsigned BIT_DEPTH      = 4,
    parameter int unsigned BASE_ON_CYCLES = 8
) (
    input  logic                                              clk,
    input  logic                                              n_reset,
    input  logic                                              enable,
`ifdef DISPLAY_BRIGHTNESS_EN
    input  logic [7:0]                                        brightness,
`endif
    output logic                                              fb_rd_en,
    output logic [$clog2(NUM_ROWS/2)+$clog2(NUM_COLS)-1:0]    fb_addr,
    input  logic [6*BIT_DEPTH-1:0]                            fb_data,
    output logic                                              bclk,
    output logic [2:0]                                        rgb_top,
    output logic [2:0]                                        rgb_bot,
    output logic [$clog2(NUM_ROWS/2)-1:0]                     addr,
    output logic                                              oe,
    output logic                                              le,
    output logic                                              frame_done
);

    localparam int unsigned RowPairs = NUM_ROWS / 2;
    localparam int unsigned RowW     = $clog2(RowPairs);
    localparam int unsigned ColW     = $clog2(NUM_COLS);
    localparam int unsigned CntW     = $clog2(2 * NUM_COLS + 1);
    localparam int unsigned OnW      = $clog2(BASE_ON_CYCLES) + BIT_DEPTH;
    localparam int unsigned PlaneW   = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam logic [CntW-1:0] ShiftLast = CntW'(2 * NUM_COLS);
    localparam logic [CntW-1:0] LastRd    = CntW'(2 * NUM_COLS - 3);

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StDisplay} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       shift_cnt_q, shift_cnt_d;
    logic [OnW-1:0]        on_cntr_q, on_cntr_d;
    logic [RowW-1:0]       row_q, row_d, nxt_row;
    logic [PlaneW-1:0]     plane_q, plane_d, nxt_plane;
    logic                  plane_wrap, row_wrap;
    logic [OnW-1:0]        on_len, on_last;
    logic [ColW-1:0]       shift_col;
    logic [BIT_DEPTH-1:0]  chan [0:5];

    logic                  fb_rd_en_q, fb_rd_en_d;
    logic [RowW+ColW-1:0]  fb_addr_q, fb_addr_d;
    logic                  bclk_q, bclk_d;
    logic [2:0]            rgb_top_q, rgb_top_d, rgb_bot_q, rgb_bot_d;
    logic [RowW-1:0]       addr_q, addr_d;
    logic                  oe_q, oe_d, le_q, le_d, frame_done_q, frame_done_d;
`ifdef DISPLAY_BRIGHTNESS_EN
    logic [7:0]            bright_q, bright_d;
    logic [OnW+7:0]        on_prod;
`endif

    always_comb begin
        state_d      = state_q;
        shift_cnt_d  = shift_cnt_q;
        on_cntr_d    = on_cntr_q;
        row_d        = row_q;
        plane_d      = plane_q;
        frame_done_d = 1'b0;

        for (int i = 0; i < 6; i++) begin
            chan[i] = fb_data[i*BIT_DEPTH +: BIT_DEPTH];
        end

        plane_wrap = (plane_q == PlaneW'(BIT_DEPTH - 1));
        row_wrap   = (row_q == RowW'(RowPairs - 1));
        nxt_plane  = plane_wrap ? '0 : plane_q + 1'b1;
        nxt_row    = !plane_wrap ? row_q : (row_wrap ? '0 : row_q + 1'b1);
        on_len     = OnW'(BASE_ON_CYCLES) << plane_q;
        on_last    = on_len - 1'b1;

        case (state_q)
            StIdle: begin
                // Column 0 must already be fetched before SHIFT starts.
                if (enable && fb_rd_en_q) begin
                    state_d     = StShift;
                    shift_cnt_d = '0;
                end
            end
            StShift: begin
                if (shift_cnt_q == ShiftLast) begin
                    state_d = StLatch;
                end else begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end
            StLatch: begin
                state_d   = StDisplay;
                on_cntr_d = '0;
            end
            StDisplay: begin
                if (on_cntr_q == on_last) begin
                    plane_d     = nxt_plane;
                    row_d       = nxt_row;
                    shift_cnt_d = '0;
                    state_d     = StShift;
                    if (plane_wrap && row_wrap) begin
                        frame_done_d = 1'b1;
                        if (!enable) begin
                            state_d = StIdle;
                        end
                    end
                end else begin
                    on_cntr_d = on_cntr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered and derived from the state being entered.
        fb_rd_en_d = 1'b0;
        fb_addr_d  = fb_addr_q;
        shift_col  = ColW'((shift_cnt_d + 1'b1) >> 1);
        if (state_d == StIdle) begin
            fb_rd_en_d = enable;
            fb_addr_d  = '0;
        end else if (state_d == StShift && shift_cnt_d[0] && shift_cnt_d <= LastRd) begin
            fb_rd_en_d = 1'b1;
            fb_addr_d  = {row_d, shift_col};
        end else if (state_d == StDisplay && on_cntr_d == on_last) begin
            // Prefetch column 0 of the next plane during the last on-cycle.
            fb_rd_en_d = 1'b1;
            fb_addr_d  = {nxt_row, ColW'(0)};
        end

        rgb_top_d = rgb_top_q;
        rgb_bot_d = rgb_bot_q;
        if (state_q == StShift && !shift_cnt_q[0] && shift_cnt_q != ShiftLast) begin
            rgb_top_d = {chan[2][plane_q], chan[1][plane_q], chan[0][plane_q]};
            rgb_bot_d = {chan[5][plane_q], chan[4][plane_q], chan[3][plane_q]};
        end

        bclk_d = (state_d == StShift) && !shift_cnt_d[0] && (shift_cnt_d != '0);
        le_d   = (state_d == StLatch);
        addr_d = (state_d == StLatch) ? row_q : addr_q;

`ifdef DISPLAY_BRIGHTNESS_EN
        bright_d = (state_d == StLatch) ? brightness : bright_q;
        on_prod  = {8'b0, on_len} * {{OnW{1'b0}}, bright_q};
        oe_d     = !((state_d == StDisplay) && (on_cntr_d < on_prod[OnW+7:8]));
`else
        oe_d     = (state_d != StDisplay);
`endif
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q      <= StIdle;
            shift_cnt_q  <= '0;
            on_cntr_q    <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_addr_q    <= '0;
            bclk_q       <= 1'b0;
            rgb_top_q    <= '0;
            rgb_bot_q    <= '0;
            addr_q       <= '0;
            oe_q         <= 1'b1;
            le_q         <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef DISPLAY_BRIGHTNESS_EN
            bright_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            on_cntr_q    <= on_cntr_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_addr_q    <= fb_addr_d;
            bclk_q       <= bclk_d;
            rgb_top_q    <= rgb_top_d;
            rgb_bot_q    <= rgb_bot_d;
            addr_q       <= addr_d;
            oe_q         <= oe_d;
            le_q         <= le_d;
            frame_done_q <= frame_done_d;
`ifdef DISPLAY_BRIGHTNESS_EN
            bright_q     <= bright_d;
`endif
        end
    end

    assign fb_rd_en   = fb_rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign bclk       = bclk_q;
    assign rgb_top    = rgb_top_q;
    assign rgb_bot    = rgb_bot_q;
    assign addr       = addr_q;
    assign oe         = oe_q;
    assign le         = le_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a frame-buffer model and a small panel model.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        enable;
    logic        fb_rd_en;
    logic [9:0]  fb_addr;
    logic [23:0] fb_data = '0;
    logic        bclk;
    logic [2:0]  rgb_top, rgb_bot;
    logic [3:0]  addr;
    logic        oe, le, frame_done;
`ifdef DISPLAY_BRIGHTNESS_EN
    logic [7:0]  brightness = 8'd255;
`endif

    always #5 clk = ~clk;

    display_scan_ctrl dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .enable     (enable),
`ifdef DISPLAY_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .fb_rd_en   (fb_rd_en),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .bclk       (bclk),
        .rgb_top    (rgb_top),
        .rgb_bot    (rgb_bot),
        .addr       (addr),
        .oe         (oe),
        .le         (le),
        .frame_done (frame_done)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Even columns: top_r = 4'b0101; odd columns: bot_g = 4'b0010.
    function automatic logic [23:0] fb_word(input logic [9:0] a);
        logic [23:0] w;
        w = '0;
        if (a[0] == 1'b0) w[3:0] = 4'b0101;
        else              w[19:16] = 4'b0010;
        return w;
    endfunction

    always @(posedge clk) if (fb_rd_en) fb_data <= fb_word(fb_addr);

    logic [63:0] sr_top_r = '0, sr_bot_g = '0, lat_top_r = '0, lat_bot_g = '0;
    always @(posedge bclk) begin
        sr_top_r <= {sr_top_r[62:0], rgb_top[0]};
        sr_bot_g <= {sr_bot_g[62:0], rgb_bot[1]};
    end
    always @(posedge le) begin
        lat_top_r <= sr_top_r;
        lat_bot_g <= sr_bot_g;
    end

    int   cyc = 0, bclk_since = 0, bclk_at_le = 0, fd_cnt = 0, fd_cyc = 0, viol = 0;
    logic bclk_prev = 1'b0;
    logic [3:0] addr_prev = '0;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bclk && !bclk_prev) bclk_since++;
        bclk_prev = bclk;
        if (le) begin
            bclk_at_le = bclk_since;
            bclk_since = 0;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (le && (!oe || bclk)) viol++;
        if (!le && addr !== addr_prev) viol++;
        addr_prev = addr;
    endtask

    task automatic wait_le(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!le && n < 1000);
        check_val(tag, le, 1'b1);
    endtask

    task automatic wait_fd(input string tag);
        int n, start;
        n = 0;
        start = fd_cnt;
        while (fd_cnt == start && n < 1000) begin
            step();
            n++;
        end
        check_val(tag, fd_cnt, start + 1);
    endtask

    function automatic int exp_run(input int p);
`ifdef DISPLAY_BRIGHTNESS_EN
        return ((8 << p) * 255) >> 8;
`else
        return 8 << p;
`endif
    endfunction

    initial begin
        int le_cnt, le_cyc0, run, fd_prev;
        bit found;
        n_reset = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_oe", oe, 1'b1);
        check_val("rst_bclk", bclk, 1'b0);
        check_val("rst_le", le, 1'b0);
        check_val("rst_addr", addr, 4'd0);
        check_val("rst_rgb_top", rgb_top, 3'd0);
        check_val("rst_rgb_bot", rgb_bot, 3'd0);
        check_val("rst_fb_rd_en", fb_rd_en, 1'b0);
        check_val("rst_frame_done", frame_done, 1'b0);

        n_reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bclk) begin
                found = 1'b1;
                break;
            end
        end
        check_val("bclk_within_4", found, 1'b1);

        le_cnt  = 0;
        le_cyc0 = 0;
        for (int p = 0; p < 4; p++) begin
            wait_le($sformatf("le_plane%0d", p));
            if (p == 0) le_cyc0 = cyc;
            le_cnt++;
            check_val("bclk_per_shift", bclk_at_le, 64);
            check_val("addr_row0", addr, 4'd0);
            if (p == 0) begin
                check_val("p0_top_r", lat_top_r, 64'hAAAA_AAAA_AAAA_AAAA);
                check_val("p0_bot_g", lat_bot_g, 64'h0);
            end
            if (p == 1) begin
                check_val("p1_top_r", lat_top_r, 64'h0);
                check_val("p1_bot_g", lat_bot_g, 64'h5555_5555_5555_5555);
            end
            step();
            check_val("oe_after_le", oe, 1'b0);
            run = 1;
            while (run < 300) begin
                step();
                if (oe) break;
                run++;
            end
            check_val($sformatf("oe_run_plane%0d", p), run, exp_run(p));
        end

        while (le_cnt < 64) begin
            wait_le("le_frame1");
            check_val("addr_at_le", addr, le_cnt / 4);
            le_cnt++;
        end
        check_val("no_early_frame_done", fd_cnt, 0);
        wait_fd("fd_frame1");
        check_val("frame1_len_from_le", fd_cyc - le_cyc0, 10111);

        fd_prev = fd_cyc;
        le_cnt  = 0;
        while (le_cnt < 64) begin
            wait_le("le_frame2");
            if (addr == 4'd5 && enable) enable = 1'b0;
            le_cnt++;
        end
        check_val("stop_last_addr", addr, 4'd15);
        wait_fd("fd_frame2");
        check_val("frame2_len", fd_cyc - fd_prev, 10240);
        check_val("fd_count", fd_cnt, 2);
        bclk_since = 0;
        repeat (300) step();
        check_val("idle_no_bclk", bclk_since, 0);
        check_val("idle_oe", oe, 1'b1);
        check_val("idle_fd_count", fd_cnt, 2);
        check_val("invariants", viol, 0);

        enable = 1'b1;
        wait_le("le_restart");
        step();
        check_val("pre_reset_oe", oe, 1'b0);
        n_reset = 1'b0;
        step();
        check_val("midrst_oe", oe, 1'b1);
        check_val("midrst_le", le, 1'b0);
        check_val("midrst_bclk", bclk, 1'b0);
        check_val("midrst_fd", frame_done, 1'b0);
        check_val("midrst_rd", fb_rd_en, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Drives the HUB75-style LED panel interface: bclk, rgb_top, rgb_bot, addr, oe and le.
- Fetches pixel words from a frame-buffer read port.
- Serialises one bit-plane of one row-pair at a time, then latches it and addresses it.
- Lights the row for a binary-weighted on-time, which gives binary-code-modulated colour depth.
- Sits between the frame buffer and the panel pins; display_sim is the bench-side panel model.

Parameters:
NUM_COLS, 64, pixels per row and bclk pulses per shift.
NUM_ROWS, 32, panel rows; NUM_ROWS/2 row-pairs, addr width 4 at default.
BIT_DEPTH, 4, bits per colour channel (bit-planes per row).
BASE_ON_CYCLES, 8, clk cycles of oe-low for plane 0; plane p gets BASE_ON_CYCLES<<p.

Ports:
clk  in  1  system clock; all logic on rising edge.
n_reset  in  1  synchronous, active-low reset.
enable  in  1  level; 1 = scan continuously, 0 = stop at end of current frame.
fb_rd_en  out  1  frame-buffer read strobe.
fb_addr  out  log2(NUM_ROWS/2)+log2(NUM_COLS)  {row, col}.
fb_data  in  6*BIT_DEPTH  {bot_b, bot_g, bot_r, top_b, top_g, top_r}; valid exactly 1 clk after fb_rd_en.
bclk  out  1  panel shift clock.
rgb_top  out  3  {b, g, r} bit of current plane, top half.
rgb_bot  out  3  {b, g, r} bit of current plane, bottom half.
addr  out  log2(NUM_ROWS/2)  row-pair select.
oe  out  1  active-low output enable (1 = blanked).
le  out  1  active-high latch pulse.
frame_done  out  1  one-cycle pulse at the end of each full frame.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low (clk, n_reset).
- Reset values: bclk=0, rgb_top=0, rgb_bot=0, addr=0, oe=1, le=0, fb_rd_en=0, frame_done=0; FSM=IDLE; row=0, plane=0.
- Reset mid-operation: the synchronous reset aborts immediately. Outputs return to reset values on the next edge; no partial frame_done.
- All outputs are registered.
- FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: oe=1. Move to SHIFT when enable=1 (row=0, plane=0).
- SHIFT: exactly 2*NUM_COLS+1 cycles; oe=1 throughout.
  - Column c: fb_rd_en=1 with fb_addr={row,c} in one cycle; rgb outputs load bit[plane] of each channel on the next edge, with bclk=0.
  - bclk is then 1 for exactly one cycle.
  - rgb changes only on edges where bclk is or goes 0, so it is stable ≥1 clk before and during bclk high.
  - Exactly NUM_COLS bclk rising edges per SHIFT; column 0 is shifted first.
- LATCH: 1 cycle; le=1, addr<=row on the same edge, oe=1.
- DISPLAY: oe=0 for exactly BASE_ON_CYCLES<<plane cycles, then oe=1 on exit. The on-time counter is log2(BASE_ON_CYCLES)+BIT_DEPTH bits wide.
- Sequencing after DISPLAY:
  - plane++.
  - If plane==BIT_DEPTH: plane=0, row++.
  - If row==NUM_ROWS/2: row=0, frame_done=1 for one cycle; go to SHIFT if enable=1, else IDLE.
  - Otherwise go to SHIFT.
- Per row-pair: BIT_DEPTH*(2*NUM_COLS+2) + BASE_ON_CYCLES*(2^BIT_DEPTH−1) cycles. Default = 640; frame = 10240.
- enable deasserted mid-frame: ignored until the frame boundary. The frame always completes with frame_done. enable reasserted in the same cycle as frame_done: continue without entering IDLE.
- addr is stable outside LATCH; le never coincides with oe=0 or bclk=1.

Optional Feature:
DISPLAY_BRIGHTNESS_EN
- Defined: adds input brightness[7:0]. In DISPLAY the state still lasts BASE_ON_CYCLES<<plane cycles, but oe=0 only while on_cntr < ((BASE_ON_CYCLES<<plane)*brightness)>>8. brightness is sampled at LATCH. brightness=0 means oe stays 1; brightness=255 means one cycle short of full.
- Undefined: no brightness port; oe=0 for the full DISPLAY period.
- Frame timing is identical in both builds.

Test Plan:
- Reset: hold n_reset=0 for 3 clks with enable=1 -> oe=1, bclk=0, le=0, addr=0, rgb=0, fb_rd_en=0, frame_done=0. Release, then a bclk pulse appears within 4 clks.
- Row shift: fb model returns top_r=4'b0101 at even cols and 0 at odd, default params -> plane 0 gives 64 bclk rises. display_sim shows top red = 64'hAAAA_AAAA_AAAA_AAAA (col 0 is the MSB after 64 shifts). Plane 1 gives all-zero.
- On-time: default params, monitor oe -> low runs of 8, 16, 32, 64 cycles for planes 0–3. Each run follows an le pulse by 1 cycle.
- Frame sequencing: run one frame -> addr steps 0..15, 64 le pulses, frame_done exactly once at cycle 10240 after the first SHIFT entry.
- Stop: drop enable at row 5 -> frame completes through addr=15, frame_done pulses, FSM idles with oe=1 and no further bclk.
- Brightness (macro on): brightness=128 -> oe low runs 4, 8, 16, 32; brightness=0 -> oe never low; frame length unchanged at 10240.
